// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: owns the architectural HI/LO registers. It runs one external
// mul/div unit at a time on latched operands, commits the unit's result, and
// stalls the EX stage only when an op depends on or conflicts with a run in flight.
module muldiv_hilo_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        pipe_stall,
    output logic [31:0] rd_data,
    output logic        mul_req,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_stall,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic        div_req,
    output logic [31:0] div_dvsr,
    output logic [31:0] div_dvnd,
    input  logic        div_stall,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // A unit's done flag is ignored until req has been high for two cycles,
    // which hides the stale flag the unit shows in its start cycle.
    localparam logic [CNT_W-1:0] CNT_MIN_DONE = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;
    localparam logic [2:0] OP_MFHI = 3'd5;
    localparam logic [2:0] OP_MFLO = 3'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] run_cnt;
    logic             op_ok;
    logic             accept;
    logic             unit_done;
    logic             run_abort;
    logic             in_run;

    assign busy   = (state != IDLE);
    assign in_run = (state == MUL_RUN) || (state == DIV_RUN);

    // Accept/stall decision, MFxx read port, done/timeout detection and next state.
    always_comb begin
        state_next = state;
        op_ok      = 1'b1;
        rd_data    = '0;
        unit_done  = 1'b0;
        run_abort  = 1'b0;
        case (op)
            OP_MULT, OP_DIV, OP_MTHI, OP_MTLO: op_ok = (state == IDLE);
            OP_MFHI, OP_MFLO:                  op_ok = (state == IDLE) || (state == RECOVER);
            default:                           op_ok = 1'b1;
        endcase
        pipe_stall = op_valid && !op_ok;
        accept     = op_valid && op_ok;
        if (accept && (op == OP_MFHI)) begin
            rd_data = hi;
        end else if (accept && (op == OP_MFLO)) begin
            rd_data = lo;
        end
        case (state)
            IDLE: begin
                if (accept && (op == OP_MULT)) begin
                    state_next = MUL_RUN;
                end else if (accept && (op == OP_DIV)) begin
                    state_next = DIV_RUN;
                end
            end
            MUL_RUN: begin
                unit_done = mul_req && !mul_stall && (run_cnt >= CNT_MIN_DONE);
                run_abort = !unit_done && (run_cnt == CNT_LAST);
                if (unit_done || run_abort) begin
                    state_next = RECOVER;
                end
            end
            DIV_RUN: begin
                unit_done = div_req && !div_stall && (run_cnt >= CNT_MIN_DONE);
                run_abort = !unit_done && (run_cnt == CNT_LAST);
                if (unit_done || run_abort) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requests follow the RUN states one cycle behind the decision; the counter restarts on each state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_req <= 1'b0;
            div_req <= 1'b0;
            run_cnt <= '0;
        end else begin
            mul_req <= (state_next == MUL_RUN);
            div_req <= (state_next == DIV_RUN);
            if (state_next != state) begin
                run_cnt <= '0;
            end else if (in_run) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    // Operands are captured only when MULT/DIV is accepted, so they hold for the whole run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a    <= '0;
            mul_b    <= '0;
            div_dvsr <= '0;
            div_dvnd <= '0;
        end else if (accept && (state == IDLE)) begin
            if (op == OP_MULT) begin
                mul_a <= rs_val;
                mul_b <= rt_val;
            end else if (op == OP_DIV) begin
                div_dvnd <= rs_val;
                div_dvsr <= rt_val;
            end
        end
    end

    // HI/LO writes from MTxx or a completed run; a watchdog abort leaves them alone and sets err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi  <= '0;
            lo  <= '0;
            err <= 1'b0;
        end else begin
            if (unit_done) begin
                hi <= (state == MUL_RUN) ? mul_hi : div_hi;
                lo <= (state == MUL_RUN) ? mul_lo : div_lo;
            end else if (accept && (state == IDLE) && (op == OP_MTHI)) begin
                hi <= rs_val;
            end else if (accept && (state == IDLE) && (op == OP_MTLO)) begin
                lo <= rs_val;
            end
            if (run_abort) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: drives directed and random op streams into muldiv_hilo_ctrl,
// models the mul/div units, and scores MFHI/MFLO reads against a HI/LO reference.
module tb_muldiv_hilo_ctrl;

    localparam int UNIT_LAT = 33;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;
    localparam logic [2:0] OP_MFHI = 3'd5;
    localparam logic [2:0] OP_MFLO = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        pipe_stall;
    logic [31:0] rd_data;
    logic        mul_req;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_stall;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        div_req;
    logic [31:0] div_dvsr;
    logic [31:0] div_dvnd;
    logic        div_stall;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        err;

    int checks = 0;
    int fails  = 0;

    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_mul_a = '0;
    logic [31:0] exp_mul_b = '0;
    logic [31:0] exp_div_dvnd = '0;
    logic [31:0] exp_div_dvsr = '0;

    int          stall_cycles;
    logic        acc_busy;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic        prev_busy;
    logic        prev_div_req;
    logic        mul_hang = 1'b0;
    int          mul_run_len = 0;
    int          last_mul_run = 0;
    int          mul_k = 0;
    int          div_k = 0;

    muldiv_hilo_ctrl #(.TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .pipe_stall (pipe_stall),
        .rd_data    (rd_data),
        .mul_req    (mul_req),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_stall  (mul_stall),
        .mul_hi     (mul_hi),
        .mul_lo     (mul_lo),
        .div_req    (div_req),
        .div_dvsr   (div_dvsr),
        .div_dvnd   (div_dvnd),
        .div_stall  (div_stall),
        .div_hi     (div_hi),
        .div_lo     (div_lo),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mul_product(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Returns {remainder, quotient}, signed, truncating toward zero.
    function automatic logic [63:0] div_result(input logic [31:0] dvnd, input logic [31:0] dvsr);
        longint q;
        longint r;
        if (dvsr == 32'd0) return 64'd0;
        q = longint'($signed(dvnd)) / longint'($signed(dvsr));
        r = longint'($signed(dvnd)) % longint'($signed(dvsr));
        return {r[31:0], q[31:0]};
    endfunction

    // Unit models: stall is low in the start cycle (stale done), high until UNIT_LAT cycles after req rose.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_k <= 0;
            div_k <= 0;
        end else begin
            mul_k <= mul_req ? mul_k + 1 : 0;
            div_k <= div_req ? div_k + 1 : 0;
        end
    end

    assign mul_stall = mul_req && (mul_k >= 1) && (mul_hang || (mul_k < UNIT_LAT));
    assign div_stall = div_req && (div_k >= 1) && (div_k < UNIT_LAT);
    assign {mul_hi, mul_lo} = (mul_k >= UNIT_LAT) ? mul_product(mul_a, mul_b) : {2{32'hBAD0BAD0}};
    assign {div_hi, div_lo} = (div_k >= UNIT_LAT) ? div_result(div_dvnd, div_dvsr) : {2{32'hBAD1BAD1}};

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one op, updates the HI/LO reference in program order, and waits for acceptance.
    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] res;
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        case (o)
            OP_MULT: if (!mul_hang) begin
                res = mul_product(a, b);
                ref_hi = res[63:32];
                ref_lo = res[31:0];
            end
            OP_DIV: begin
                res = div_result(a, b);
                ref_hi = res[63:32];
                ref_lo = res[31:0];
            end
            OP_MTHI: ref_hi = a;
            OP_MTLO: ref_lo = a;
            OP_MFHI: exp_q.push_back(ref_hi);
            OP_MFLO: exp_q.push_back(ref_lo);
            default: ;
        endcase
        stall_cycles = 0;
        prev_busy    = 1'b0;
        prev_div_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!pipe_stall) break;
            prev_busy    = busy;
            prev_div_req = div_req;
            stall_cycles++;
            if (stall_cycles > 200) begin
                checks++;
                fails++;
                $display("[TB] FAIL accept_timeout: op %0d still stalled after %0d cycles, expected acceptance", o, stall_cycles);
                break;
            end
        end
        acc_busy = busy;
        acc_hi   = hi;
        acc_lo   = lo;
        if (o == OP_MULT) begin
            exp_mul_a = a;
            exp_mul_b = b;
        end else if (o == OP_DIV) begin
            exp_div_dvnd = a;
            exp_div_dvsr = b;
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = OP_NOP;
    endtask

    // Monitor: scoreboard for MFxx reads, req exclusivity, operand stability, mul req run length.
    always @(negedge clk) begin
        if (rst) begin
            check_output("req_exclusive", {31'd0, mul_req && div_req}, 32'd0);
            if (mul_req) begin
                check_output("mul_a_stable", mul_a, exp_mul_a);
                check_output("mul_b_stable", mul_b, exp_mul_b);
            end
            if (div_req) begin
                check_output("div_dvnd_stable", div_dvnd, exp_div_dvnd);
                check_output("div_dvsr_stable", div_dvsr, exp_div_dvsr);
            end
            if (op_valid && !pipe_stall && ((op == OP_MFHI) || (op == OP_MFLO))) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL scoreboard_empty: rd_data 0x%08h with no expected value queued", rd_data);
                end else begin
                    check_output((op == OP_MFHI) ? "mfhi_data" : "mflo_data", rd_data, exp_q.pop_front());
                end
            end else begin
                check_output("rd_data_idle", rd_data, 32'd0);
            end
            if (mul_req) begin
                mul_run_len <= mul_run_len + 1;
            end else if (mul_run_len != 0) begin
                last_mul_run <= mul_run_len;
                mul_run_len  <= 0;
            end
        end else begin
            mul_run_len <= 0;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wait_cycles;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_hi", hi, 32'd0);
        check_output("reset_lo", lo, 32'd0);
        check_output("reset_mul_req", {31'd0, mul_req}, 32'd0);
        check_output("reset_div_req", {31'd0, div_req}, 32'd0);
        check_output("reset_mul_a", mul_a, 32'd0);
        check_output("reset_mul_b", mul_b, 32'd0);
        check_output("reset_div_dvsr", div_dvsr, 32'd0);
        check_output("reset_div_dvnd", div_dvnd, 32'd0);
        check_output("reset_err", {31'd0, err}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_rd_data", rd_data, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] MTxx / MFxx round trip");
        apply_stimulus(OP_MTHI, 32'hDEADBEEF, 32'd0);
        check_output("mthi_stall", 32'(stall_cycles), 32'd0);
        apply_stimulus(OP_MTLO, 32'h12345678, 32'd0);
        check_output("mtlo_stall", 32'(stall_cycles), 32'd0);
        apply_stimulus(OP_MFHI, 32'd0, 32'd0);
        check_output("mfhi_stall", 32'(stall_cycles), 32'd0);
        apply_stimulus(OP_MFLO, 32'd0, 32'd0);
        check_output("mflo_stall", 32'(stall_cycles), 32'd0);

        // MULT issues at no cost; req is high t..t+33, dependent MFLO waits t..t+33 and lands in RECOVER.
        $display("[TB] MULT 7 * -3 with dependent MFLO");
        apply_stimulus(OP_MULT, 32'd7, 32'hFFFFFFFD);
        check_output("mult_issue_stall", 32'(stall_cycles), 32'd0);
        apply_stimulus(OP_MFLO, 32'd0, 32'd0);
        check_output("dep_mflo_stall", 32'(stall_cycles), 32'd34);
        check_output("dep_mflo_in_recover", {31'd0, acc_busy}, 32'd1);
        check_output("mul_req_len", 32'(last_mul_run), 32'd34);
        apply_stimulus(OP_MFHI, 32'd0, 32'd0);
        check_output("mfhi_after_mult_stall", 32'(stall_cycles), 32'd0);

        // Back-to-back DIV waits until IDLE, one RECOVER cycle with div_req low right before.
        $display("[TB] DIV -17 / 5 then DIV 100 / 7");
        apply_stimulus(OP_DIV, 32'hFFFFFFEF, 32'd5);
        apply_stimulus(OP_DIV, 32'd100, 32'd7);
        check_output("b2b_div_stall", 32'(stall_cycles), 32'd35);
        check_output("b2b_div_in_idle", {31'd0, acc_busy}, 32'd0);
        check_output("recover_busy", {31'd0, prev_busy}, 32'd1);
        check_output("recover_div_req", {31'd0, prev_div_req}, 32'd0);
        check_output("div1_hi", acc_hi, 32'hFFFFFFFE);
        check_output("div1_lo", acc_lo, 32'hFFFFFFFD);
        apply_stimulus(OP_MFLO, 32'd0, 32'd0);
        apply_stimulus(OP_MFHI, 32'd0, 32'd0);

        // A unit that never finishes: req high for TIMEOUT cycles, then RECOVER, then IDLE.
        $display("[TB] MULT with hung unit");
        mul_hang = 1'b1;
        apply_stimulus(OP_MULT, 32'd5, 32'd6);
        apply_stimulus(OP_MTHI, 32'hCAFEF00D, 32'd0);
        check_output("timeout_mthi_stall", 32'(stall_cycles), 32'd65);
        check_output("timeout_hi_kept", acc_hi, 32'd2);
        check_output("timeout_lo_kept", acc_lo, 32'd14);
        check_output("timeout_req_len", 32'(last_mul_run), 32'd64);
        check_output("timeout_err", {31'd0, err}, 32'd1);
        mul_hang = 1'b0;
        apply_stimulus(OP_MFHI, 32'd0, 32'd0);
        check_output("err_sticky", {31'd0, err}, 32'd1);

        $display("[TB] reset in the middle of a DIV");
        apply_stimulus(OP_DIV, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("midrst_busy", {31'd0, busy}, 32'd0);
        check_output("midrst_div_req", {31'd0, div_req}, 32'd0);
        check_output("midrst_hi", hi, 32'd0);
        check_output("midrst_lo", lo, 32'd0);
        check_output("midrst_err", {31'd0, err}, 32'd0);
        check_output("midrst_div_dvnd", div_dvnd, 32'd0);
        ref_hi = '0;
        ref_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(OP_MULT, 32'h00010000, 32'h00010000);
        apply_stimulus(OP_MFHI, 32'd0, 32'd0);
        apply_stimulus(OP_MFLO, 32'd0, 32'd0);

        $display("[TB] randomized op stream");
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  r_op;
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
            if ((r_op == OP_DIV) && (r_b == 32'd0)) r_b = 32'd1;
            apply_stimulus(r_op, r_a, r_b);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        apply_stimulus(OP_MFHI, 32'd0, 32'd0);
        apply_stimulus(OP_MFLO, 32'd0, 32'd0);

        wait_cycles = 0;
        while (busy && (wait_cycles < 100)) begin
            @(posedge clk);
            #1;
            wait_cycles++;
        end
        check_output("final_idle", {31'd0, busy}, 32'd0);
        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check_output("final_err", {31'd0, err}, 32'd0);
        check_output("final_hi", hi, ref_hi);
        check_output("final_lo", lo, ref_lo);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
